// File: rtl/psum_accum_buf_pkg.sv
// psum_accum_buf_pkg: FSM states and lane helpers; PSUM_ACC_SAT_EN adds the saturating add
package psum_accum_buf_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
  function automatic int lane_lsb(input int lane, input int bw);
    return lane * bw;
  endfunction
`ifdef PSUM_ACC_SAT_EN
  function automatic longint sat_add(input longint a, input longint b, input int bw);
    longint s, hi, lo;
    s = a + b;
    hi = (longint'(1) <<< (bw - 1)) - 1;
    lo = -hi - 1;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
`endif
endpackage

// File: rtl/psum_accum_buf_if.sv
// psum_accum_buf_if: write, readback and clear signals of the psum buffer
interface psum_accum_buf_if #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int DEPTH   = 2048
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = COL * PSUM_BW;
  logic          in_valid, in_ready, in_acc, rd_en, rd_valid, clear, busy;
  logic [AW-1:0] in_addr, rd_addr;
  logic [W-1:0]  in_data, rd_data;
  modport master (
    output in_valid, in_addr, in_acc, in_data, rd_en, rd_addr, clear,
    input  in_ready, rd_valid, rd_data, busy
  );
  modport slave (
    input  in_valid, in_addr, in_acc, in_data, rd_en, rd_addr, clear,
    output in_ready, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/psum_lane_add.sv
// psum_lane_add: one signed lane add, two's-complement wrap, saturating when PSUM_ACC_SAT_EN is defined
module psum_lane_add
  import psum_accum_buf_pkg::*;
#(
  parameter int PSUM_BW = 16
) (
  input  logic signed [PSUM_BW-1:0] a,
  input  logic signed [PSUM_BW-1:0] b,
  output logic signed [PSUM_BW-1:0] y
);
`ifdef PSUM_ACC_SAT_EN
  assign y = PSUM_BW'(sat_add(longint'(a), longint'(b), PSUM_BW));
`else
  assign y = a + b;
`endif
endmodule

// File: rtl/psum_accum_buf.sv
// psum_accum_buf: psum buffer with pipelined accumulate, readback and clear sequencer (PSUM_ACC_SAT_EN: saturating accumulate)
module psum_accum_buf
  import psum_accum_buf_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int DEPTH   = 2048
) (
  input logic             clk,
  input logic             reset,
  psum_accum_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = COL * PSUM_BW;
  state_t        state, state_nx;
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  mem_q, byp_q, s_data, old, sum, upd, wr_data, rd_hold;
  logic [AW-1:0] cnt, raddr, s_addr, wr_addr;
  logic          s_valid, s_acc, byp, rd_valid, wr_en, accept, rd_fire;
  assign bus.in_ready = !reset && state == IDLE && !bus.rd_en && !bus.clear;
  assign accept       = bus.in_valid && bus.in_ready;
  assign rd_fire      = bus.rd_en && state == IDLE;
  assign raddr        = bus.rd_en ? bus.rd_addr : bus.in_addr;
  // A write landing on the address being read this cycle is forwarded next cycle
  assign old          = byp ? byp_q : mem_q;
  assign upd          = s_acc ? sum : s_data;
  assign wr_en        = !reset && (s_valid || state == CLEAR);
  assign wr_addr      = state == CLEAR ? cnt : s_addr;
  assign wr_data      = state == CLEAR ? '0 : upd;
  assign bus.busy     = !reset && state != IDLE;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_valid ? old : rd_hold;
  for (genvar i = 0; i < COL; i++) begin : g_lane
    psum_lane_add #(.PSUM_BW(PSUM_BW)) u_add (
      .a(old[lane_lsb(i, PSUM_BW) +: PSUM_BW]),
      .b(s_data[lane_lsb(i, PSUM_BW) +: PSUM_BW]),
      .y(sum[lane_lsb(i, PSUM_BW) +: PSUM_BW])
    );
  end
  always_comb begin
    state_nx = state == IDLE  ? (bus.clear ? (s_valid ? DRAIN : CLEAR) : IDLE) :
               state == DRAIN ? (s_valid ? DRAIN : CLEAR) :
               (cnt == AW'(DEPTH - 1) ? IDLE : CLEAR);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      s_valid  <= 1'b0;
      rd_valid <= 1'b0;
      rd_hold  <= '0;
      byp      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= state == CLEAR && state_nx == CLEAR ? cnt + AW'(1) : '0;
      s_valid  <= accept;
      rd_valid <= rd_fire;
      byp      <= wr_en && wr_addr == raddr;
      if (rd_valid) rd_hold <= old;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      s_addr <= bus.in_addr;
      s_acc  <= bus.in_acc;
      s_data <= bus.in_data;
    end
    byp_q <= wr_data;
    mem_q <= mem[raddr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_psum_accum_buf.sv
// tb_psum_accum_buf: randomized scoreboard bench for psum_accum_buf against a sequential memory model
module tb_psum_accum_buf;
  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 2048;
  localparam int AW      = $clog2(DEPTH);
  localparam int W       = COL * PSUM_BW;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] model_mem [DEPTH];
  logic [W-1:0] exp_q [$];
  psum_accum_buf_if #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) bus ();
  psum_accum_buf #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [W-1:0] fill(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PSUM_BW +: PSUM_BW] = PSUM_BW'(v);
    return r;
  endfunction
  function automatic logic [W-1:0] apply(input logic [W-1:0] old, input logic [W-1:0] d, input logic acc);
    logic [W-1:0] r;
    int s;
    if (!acc) return d;
    for (int i = 0; i < COL; i++) begin
      s = int'($signed(old[i*PSUM_BW +: PSUM_BW])) + int'($signed(d[i*PSUM_BW +: PSUM_BW]));
`ifdef PSUM_ACC_SAT_EN
      if (s > (1 << (PSUM_BW - 1)) - 1) s = (1 << (PSUM_BW - 1)) - 1;
      if (s < -(1 << (PSUM_BW - 1))) s = -(1 << (PSUM_BW - 1));
`endif
      r[i*PSUM_BW +: PSUM_BW] = PSUM_BW'(s);
    end
    return r;
  endfunction
  always @(negedge clk) begin
    if (!reset && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: rd_valid=1 expected 0");
      end else check("rd_data", bus.rd_data, exp_q.pop_front());
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input logic acc, input logic [W-1:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_addr  = AW'(a);
    bus.in_acc   = acc;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("in_ready_wr", W'(bus.in_ready), W'(1));
    if (bus.in_ready) model_mem[a] = apply(model_mem[a], d, acc);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic rd_exp(input int a, input logic [W-1:0] e);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(a);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
  endtask
  task automatic rd(input int a);
    rd_exp(a, model_mem[a]);
  endtask
  task automatic clear_and_wait(output int n);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < DEPTH + 100) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask
  initial begin
    int nb;
    logic [W-1:0] base, inc, e;
    bus.in_valid = 1'b1;
    bus.in_addr  = '0;
    bus.in_acc   = 1'b0;
    bus.in_data  = '0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    bus.clear    = 1'b0;
    repeat (2) @(negedge clk);
    check("in_ready_in_reset", W'(bus.in_ready), '0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", W'(bus.in_ready), W'(1));
    check("busy_after_reset", W'(bus.busy), '0);
    check("rd_valid_after_reset", W'(bus.rd_valid), '0);
    check("rd_data_after_reset", bus.rd_data, '0);
    @(posedge clk);
    #1;
    clear_and_wait(nb);
    check("busy_cycles_empty", W'(nb), W'(DEPTH));
    wr(5, 1'b0, fill(3));
    rd_exp(5, fill(3));
    idle(1);
    @(negedge clk);
    check("rd_valid_idle", W'(bus.rd_valid), '0);
    check("rd_data_hold", bus.rd_data, fill(3));
    @(posedge clk);
    #1;
    wr(7, 1'b0, fill(10));
    wr(7, 1'b1, fill(1));
    wr(7, 1'b1, fill(2));
    wr(7, 1'b1, fill(3));
    rd_exp(7, fill(16));
    for (int i = 0; i < COL; i++) begin
      base[i*PSUM_BW +: PSUM_BW] = i == 0 ? 16'h7FFF : PSUM_BW'(i * 1000 - 3000);
      inc[i*PSUM_BW +: PSUM_BW]  = i == 0 ? 16'h0001 : 16'h0005;
`ifdef PSUM_ACC_SAT_EN
      e[i*PSUM_BW +: PSUM_BW] = i == 0 ? 16'h7FFF : PSUM_BW'(i * 1000 - 2995);
`else
      e[i*PSUM_BW +: PSUM_BW] = i == 0 ? 16'h8000 : PSUM_BW'(i * 1000 - 2995);
`endif
    end
    wr(12, 1'b0, base);
    wr(12, 1'b1, inc);
    rd_exp(12, e);
    bus.rd_en    = 1'b1;
    bus.rd_addr  = AW'(5);
    exp_q.push_back(fill(3));
    bus.in_valid = 1'b1;
    bus.in_addr  = AW'(9);
    bus.in_acc   = 1'b0;
    bus.in_data  = fill(-7);
    @(negedge clk);
    check("in_ready_rd_prio", W'(bus.in_ready), '0);
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    @(negedge clk);
    check("in_ready_after_rd", W'(bus.in_ready), W'(1));
    model_mem[9] = fill(-7);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rd_exp(9, fill(-7));
    for (int k = 0; k < 400; k++) begin
      int a, op;
      logic [W-1:0] d;
      a  = $urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH - 1) : $urandom_range(40, 47);
      op = $urandom_range(0, 9);
      d  = {$urandom, $urandom, $urandom, $urandom};
      if (op < 3) wr(a, 1'b0, d);
      else if (op < 6) wr(a, 1'b1, d);
      else if (op < 9) rd(a);
      else idle(1);
    end
    idle(2);
    wr(20, 1'b0, fill(55));
    clear_and_wait(nb);
    check("busy_cycles_inflight", W'(nb), W'(DEPTH + 1));
    for (int i = 0; i < DEPTH; i++) rd_exp(i, '0);
    for (int i = 90; i <= 110; i++) wr(i, 1'b0, {$urandom, $urandom, $urandom, $urandom});
    idle(1);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 100; i++) model_mem[i] = '0;
    @(negedge clk);
    check("busy_after_abort", W'(bus.busy), '0);
    check("in_ready_after_abort", W'(bus.in_ready), W'(1));
    check("rd_valid_after_abort", W'(bus.rd_valid), '0);
    @(posedge clk);
    #1;
    for (int i = 90; i < 100; i++) rd(i);
    for (int i = 101; i <= 110; i++) rd(i);
    rd(0);
    idle(5);
    check("reads_outstanding", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
